// File: rtl/pipe_fp16_result_collect_if.sv
// Lane-side and output-side signals of the fp16 div/sqrt result collector.
// The slave modport is the collector; the master modport is the lane array plus the consumer.
interface pipe_fp16_result_collect_if #(
  parameter int NUM_LANES = 5,
  parameter int WIDTH     = 16,
  parameter int STATUS_W  = 5
) ();
  localparam int PTR_W = $clog2(NUM_LANES);

  logic                          flush_i;
  logic [NUM_LANES-1:0]          lane_valid_i;
  logic [NUM_LANES*WIDTH-1:0]    lane_result_i;
  logic [NUM_LANES*STATUS_W-1:0] lane_status_i;
  logic [NUM_LANES-1:0]          lane_ready_o;
  logic                          out_valid_o;
  logic                          out_ready_i;
  logic [WIDTH-1:0]              out_result_o;
  logic [STATUS_W-1:0]           out_status_o;
  logic [PTR_W-1:0]              out_lane_o;
  logic [PTR_W:0]                pending_o;
  logic                          overflow_o;

  modport slave (
    input  flush_i, lane_valid_i, lane_result_i, lane_status_i, out_ready_i,
    output lane_ready_o, out_valid_o, out_result_o, out_status_o, out_lane_o,
           pending_o, overflow_o
  );

  modport master (
    output flush_i, lane_valid_i, lane_result_i, lane_status_i, out_ready_i,
    input  lane_ready_o, out_valid_o, out_result_o, out_status_o, out_lane_o,
           pending_o, overflow_o
  );
endinterface

// File: rtl/pipe_fp16_result_collect.sv
// One-entry slot per lane, re-serialised in lane-rotation order; lane-to-output latency is one cycle.
// A lane is stalled while its slot is full unless the slot drains that same cycle; excess results raise sticky overflow.
module pipe_fp16_result_collect #(
  parameter int NUM_LANES = 5,
  parameter int WIDTH     = 16,
  parameter int STATUS_W  = 5,
  localparam int PTR_W    = $clog2(NUM_LANES)
) (
  input logic                          CLK_i,
  input logic                          RST_i,
  pipe_fp16_result_collect_if.slave    bus
);

  logic [NUM_LANES-1:0]                slot_full_q, slot_full_d;
  logic [NUM_LANES-1:0][WIDTH-1:0]     slot_res_q, slot_res_d;
  logic [NUM_LANES-1:0][STATUS_W-1:0]  slot_sts_q, slot_sts_d;
  logic [PTR_W-1:0]                    ptr_q, ptr_d;
  logic                                overflow_q, overflow_d;
  logic [PTR_W:0]                      pending_q, pending_d;
  logic                                drain;
  logic [NUM_LANES-1:0]                lane_ready;

  // A slot being drained this cycle can be refilled in the same cycle.
  always_comb begin
    drain = slot_full_q[ptr_q] & bus.out_ready_i;
    for (int i = 0; i < NUM_LANES; i++) begin
      lane_ready[i] = ~slot_full_q[i] | (drain & (ptr_q == PTR_W'(i)));
    end
  end

  always_comb begin
    slot_full_d = slot_full_q;
    slot_res_d  = slot_res_q;
    slot_sts_d  = slot_sts_q;
    ptr_d       = ptr_q;
    overflow_d  = overflow_q | (|(bus.lane_valid_i & ~lane_ready));

    if (drain) begin
      slot_full_d[ptr_q] = 1'b0;
      ptr_d = (ptr_q == PTR_W'(NUM_LANES - 1)) ? '0 : ptr_q + 1'b1;
    end

    for (int i = 0; i < NUM_LANES; i++) begin
      if (bus.lane_valid_i[i] & lane_ready[i]) begin
        slot_full_d[i] = 1'b1;
        slot_res_d[i]  = bus.lane_result_i[i*WIDTH +: WIDTH];
        slot_sts_d[i]  = bus.lane_status_i[i*STATUS_W +: STATUS_W];
      end
    end

    // Flush discards same-cycle lane traffic, so it cannot raise overflow either.
    if (bus.flush_i) begin
      slot_full_d = '0;
      slot_res_d  = '0;
      slot_sts_d  = '0;
      ptr_d       = '0;
      overflow_d  = overflow_q;
    end

    pending_d = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      pending_d = pending_d + (PTR_W+1)'(slot_full_d[i]);
    end
  end

  always_ff @(posedge CLK_i) begin
    if (RST_i) begin
      slot_full_q <= '0;
      slot_res_q  <= '0;
      slot_sts_q  <= '0;
      ptr_q       <= '0;
      overflow_q  <= 1'b0;
      pending_q   <= '0;
    end else begin
      slot_full_q <= slot_full_d;
      slot_res_q  <= slot_res_d;
      slot_sts_q  <= slot_sts_d;
      ptr_q       <= ptr_d;
      overflow_q  <= overflow_d;
      pending_q   <= pending_d;
    end
  end

  assign bus.lane_ready_o = lane_ready;
  assign bus.out_valid_o  = slot_full_q[ptr_q];
  assign bus.out_result_o = slot_res_q[ptr_q];
  assign bus.out_status_o = slot_sts_q[ptr_q];
  assign bus.out_lane_o   = ptr_q;
  assign bus.pending_o    = pending_q;
  assign bus.overflow_o   = overflow_q;

endmodule

// File: tb/tb_pipe_fp16_result_collect.sv
// Directed scenarios plus random traffic, checked every cycle against a slot/rotation model.
module tb_pipe_fp16_result_collect;
  localparam int N = 5;
  localparam int W = 16;
  localparam int S = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pipe_fp16_result_collect_if #(.NUM_LANES(N), .WIDTH(W), .STATUS_W(S)) bus ();

  pipe_fp16_result_collect #(.NUM_LANES(N), .WIDTH(W), .STATUS_W(S)) dut (
    .CLK_i (clk),
    .RST_i (rst),
    .bus   (bus)
  );

  // Model state: what each slot holds, which slot is next in issue order, sticky error.
  bit           m_full [N];
  logic [W-1:0] m_res  [N];
  logic [S-1:0] m_sts  [N];
  int           m_ptr;
  bit           m_ovf;
  bit           m_live = 1'b0;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear(input bit keep_ovf);
    for (int i = 0; i < N; i++) begin
      m_full[i] = 1'b0;
      m_res[i]  = '0;
      m_sts[i]  = '0;
    end
    m_ptr = 0;
    if (!keep_ovf) m_ovf = 1'b0;
  endtask

  task automatic compare_and_advance();
    int           cnt;
    bit           drain;
    logic [N-1:0] rdy;
    cnt   = 0;
    drain = m_full[m_ptr] && bus.out_ready_i;
    for (int i = 0; i < N; i++) begin
      cnt += int'(m_full[i]);
      rdy[i] = !m_full[i] || (drain && m_ptr == i);
    end
    chk("out_valid",  32'(bus.out_valid_o),  32'(m_full[m_ptr]));
    chk("out_result", 32'(bus.out_result_o), 32'(m_res[m_ptr]));
    chk("out_status", 32'(bus.out_status_o), 32'(m_sts[m_ptr]));
    chk("out_lane",   32'(bus.out_lane_o),   32'(m_ptr));
    chk("pending",    32'(bus.pending_o),    32'(cnt));
    chk("overflow",   32'(bus.overflow_o),   32'(m_ovf));
    chk("lane_ready", 32'(bus.lane_ready_o), 32'(rdy));

    if (rst) begin
      model_clear(1'b0);
    end else if (bus.flush_i) begin
      model_clear(1'b1);
    end else begin
      if (drain) begin
        m_full[m_ptr] = 1'b0;
        m_ptr = (m_ptr + 1) % N;
      end
      for (int i = 0; i < N; i++) begin
        if (bus.lane_valid_i[i]) begin
          if (rdy[i]) begin
            m_full[i] = 1'b1;
            m_res[i]  = bus.lane_result_i[i*W +: W];
            m_sts[i]  = bus.lane_status_i[i*S +: S];
          end else begin
            m_ovf = 1'b1;
          end
        end
      end
    end
  endtask

  // One clock: compare at the falling edge, then land 1 time unit after the rising edge.
  task automatic step();
    @(negedge clk);
    if (m_live) compare_and_advance();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_lanes();
    bus.lane_valid_i  = '0;
    bus.lane_result_i = '0;
    bus.lane_status_i = '0;
  endtask

  task automatic put(input int i, input logic [W-1:0] r, input logic [S-1:0] s);
    bus.lane_valid_i[i]           = 1'b1;
    bus.lane_result_i[i*W +: W]   = r;
    bus.lane_status_i[i*S +: S]   = s;
  endtask

  logic [W-1:0] t1_res [N];
  logic [W-1:0] t3_res [N];

  initial begin
    t1_res = '{16'h4000, 16'h3C00, 16'h7E00, 16'h4200, 16'h0000};
    t3_res = '{16'hA000, 16'hA111, 16'hA222, 16'hA333, 16'hA444};
    bus.flush_i     = 1'b0;
    bus.out_ready_i = 1'b0;
    idle_lanes();

    // Reset
    rst = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    model_clear(1'b0);
    m_live = 1'b1;
    chk("rst_out_valid",  32'(bus.out_valid_o),  32'd0);
    chk("rst_out_result", 32'(bus.out_result_o), 32'd0);
    chk("rst_pending",    32'(bus.pending_o),    32'd0);
    chk("rst_overflow",   32'(bus.overflow_o),   32'd0);
    chk("rst_lane_ready", 32'(bus.lane_ready_o), 32'h1F);
    rst = 1'b0;
    step();

    // In-order results, one cycle of latency each, lane index wraps
    bus.out_ready_i = 1'b1;
    for (int k = 0; k < N; k++) begin
      idle_lanes();
      put(k, t1_res[k], (k == 2) ? 5'b10000 : 5'b00000);
      step();
      chk("t1_valid",  32'(bus.out_valid_o),  32'd1);
      chk("t1_result", 32'(bus.out_result_o), 32'(t1_res[k]));
      chk("t1_lane",   32'(bus.out_lane_o),   32'(k));
      if (k == 2) chk("t1_status", 32'(bus.out_status_o), 32'b10000);
    end
    idle_lanes();
    step();
    chk("t1_wrap_lane",  32'(bus.out_lane_o),  32'd0);
    chk("t1_wrap_valid", 32'(bus.out_valid_o), 32'd0);

    // Out-of-order completion held until lane 0 arrives
    put(2, 16'h4400, '0); step(); idle_lanes();
    chk("t2_pend1", 32'(bus.pending_o), 32'd1);
    chk("t2_nov1",  32'(bus.out_valid_o), 32'd0);
    put(1, 16'h3800, '0); step(); idle_lanes();
    chk("t2_pend2", 32'(bus.pending_o), 32'd2);
    chk("t2_nov2",  32'(bus.out_valid_o), 32'd0);
    put(0, 16'h3000, '0); step(); idle_lanes();
    chk("t2_pend3", 32'(bus.pending_o), 32'd3);
    chk("t2_r0",    32'(bus.out_result_o), 32'h3000);
    step();
    chk("t2_pend4", 32'(bus.pending_o), 32'd2);
    chk("t2_r1",    32'(bus.out_result_o), 32'h3800);
    step();
    chk("t2_pend5", 32'(bus.pending_o), 32'd1);
    chk("t2_r2",    32'(bus.out_result_o), 32'h4400);
    step();
    chk("t2_pend6", 32'(bus.pending_o), 32'd0);

    // Backpressure with every slot full (pointer now at lane 3)
    bus.out_ready_i = 1'b0;
    for (int i = 0; i < N; i++) put(i, t3_res[i], S'(i));
    step(); idle_lanes();
    chk("t3_pend",  32'(bus.pending_o),    32'd5);
    chk("t3_rdy",   32'(bus.lane_ready_o), 32'd0);
    put(3, 16'hDEAD, 5'h1F); step(); idle_lanes();
    chk("t3_ovf",   32'(bus.overflow_o),   32'd1);
    chk("t3_keep3", 32'(bus.out_result_o), 32'hA333);
    bus.out_ready_i = 1'b1;
    for (int k = 0; k < N; k++) begin
      chk("t3_drain", 32'(bus.out_result_o), 32'(t3_res[(3 + k) % N]));
      step();
    end
    chk("t3_empty", 32'(bus.pending_o), 32'd0);

    // Same-cycle drain and refill of lane 0
    bus.flush_i = 1'b1; step(); bus.flush_i = 1'b0;
    bus.out_ready_i = 1'b0;
    put(0, 16'h1111, '0); step(); idle_lanes();
    bus.out_ready_i = 1'b1;
    put(0, 16'h5000, '0);
    #1;
    chk("t4_rdy0", 32'(bus.lane_ready_o[0]), 32'd1);
    chk("t4_old",  32'(bus.out_result_o),    32'h1111);
    step(); idle_lanes();
    for (int i = 1; i < N; i++) put(i, 16'h6000 + 16'(i), '0);
    step(); idle_lanes();
    for (int k = 1; k < N; k++) step();
    chk("t4_new",  32'(bus.out_result_o), 32'h5000);
    chk("t4_lane", 32'(bus.out_lane_o),   32'd0);
    step();

    // Flush keeps overflow and drops same-cycle lane input
    bus.out_ready_i = 1'b0;
    put(1, 16'h1234, '0); put(3, 16'h5678, '0); step(); idle_lanes();
    bus.flush_i = 1'b1;
    put(2, 16'h7777, 5'h3);
    step();
    bus.flush_i = 1'b0; idle_lanes();
    chk("t5_pend",  32'(bus.pending_o),    32'd0);
    chk("t5_valid", 32'(bus.out_valid_o),  32'd0);
    chk("t5_lane",  32'(bus.out_lane_o),   32'd0);
    chk("t5_ovf",   32'(bus.overflow_o),   32'd1);
    chk("t5_rdy",   32'(bus.lane_ready_o), 32'h1F);

    // Reset overrides flush mid-stream
    for (int i = 0; i < 3; i++) put(i, 16'h2000 + 16'(i), '0);
    step(); idle_lanes();
    chk("t6_pend3", 32'(bus.pending_o), 32'd3);
    rst = 1'b1; bus.flush_i = 1'b1;
    step();
    rst = 1'b0; bus.flush_i = 1'b0;
    chk("t6_pend",   32'(bus.pending_o),    32'd0);
    chk("t6_ovf",    32'(bus.overflow_o),   32'd0);
    chk("t6_valid",  32'(bus.out_valid_o),  32'd0);
    chk("t6_result", 32'(bus.out_result_o), 32'd0);
    chk("t6_lane",   32'(bus.out_lane_o),   32'd0);

    // Random traffic against the model
    for (int c = 0; c < 3000; c++) begin
      idle_lanes();
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 2) == 0) put(i, W'($urandom), S'($urandom));
      end
      bus.out_ready_i = ($urandom_range(0, 3) != 0);
      bus.flush_i     = ($urandom_range(0, 99) == 0);
      rst             = ($urandom_range(0, 299) == 0);
      step();
    end
    rst = 1'b0; bus.flush_i = 1'b0; idle_lanes();
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/pipe_fp16_result_collect.md
Name: pipe_fp16_result_collect

Overview:
- Downstream of the round-robin fp16 div/sqrt lane array, where operands are dealt to lanes 0,1,…,NUM_LANES-1,0,… in strict rotation.
- Captures each lane's result and status flags into a one-entry per-lane slot.
- Re-serialises the captured results in issue (lane-rotation) order onto a single valid/ready output stream.
- Provides per-lane backpressure, a pending count and a sticky overflow error.

Parameters:
- NUM_LANES, 5, number of div/sqrt lanes; must be at least 2.
- WIDTH, 16, result width in bits (fp16).
- STATUS_W, 5, width of the per-result exception flags (NV,DZ,OF,UF,NX).
- PTR_W, $clog2(NUM_LANES), width of the rotation pointer; derived, do not override.

Ports:
- CLK_i  in  1  clock; all state updates on the rising edge.
- RST_i  in  1  reset; synchronous, active-high.
- flush_i  in  1  synchronous flush; clears all slots and the pointer.
- lane_valid_i  in  NUM_LANES  lane i presents a finished result this cycle.
- lane_result_i  in  NUM_LANES*WIDTH  result of lane i, packed with lane 0 in the LSBs.
- lane_status_i  in  NUM_LANES*STATUS_W  flags of lane i, packed with lane 0 in the LSBs.
- lane_ready_o  out  NUM_LANES  slot i can accept a result this cycle.
- out_valid_o  out  1  the head result is available.
- out_ready_i  in  1  the consumer accepts the head result.
- out_result_o  out  WIDTH  head result.
- out_status_o  out  STATUS_W  head flags.
- out_lane_o  out  PTR_W  lane index of the head result (equals the pointer).
- pending_o  out  PTR_W+1  number of occupied slots.
- overflow_o  out  1  sticky: a result arrived at a slot that could not accept it.

Behaviour:
- Reset: when RST_i=1 at an edge, state is set as follows and RST_i overrides flush_i and all other inputs.
  - all slot_full bits = 0
  - ptr = 0
  - overflow = 0
  - slot data = 0
- Outputs after reset:
  - out_valid_o=0, out_result_o=0, out_status_o=0, out_lane_o=0
  - pending_o=0, overflow_o=0
  - lane_ready_o all 1
- Flush: when flush_i=1 (and RST_i=0), the result is identical to reset except that overflow is retained. Lane inputs arriving in the same cycle are discarded.
- Head path: out_valid_o = slot_full[ptr]. out_result_o, out_status_o and out_lane_o are driven from slot[ptr] and ptr, which are registers; there is no combinational path from lane_* inputs to the out_* ports.
- Drain: drain = out_valid_o & out_ready_i.
  - On drain, slot_full[ptr] clears.
  - ptr advances to ptr+1, wrapping from NUM_LANES-1 to 0.
  - The pointer never advances without a drain; a missing head result stalls the output even if later slots are full.
- Lane ready: lane_ready_o[i] = ~slot_full[i] | (drain & ptr==i). Same-cycle drain and refill of one lane is allowed.
- Capture:
  - lane_valid_i[i] & lane_ready_o[i] writes the result and status into slot i and sets slot_full[i] at the edge.
  - The earliest out_valid_o for that result is the next cycle, i.e. one cycle of latency from lane to output when ptr==i.
- Overflow: lane_valid_i[i] & ~lane_ready_o[i] sets overflow. The incoming data is dropped and slot i is unchanged. overflow clears only on RST_i.
- Multiple lanes may be valid in the same cycle; each lane is captured independently.
- pending_o: registered popcount of slot_full, updated each edge. Range 0..NUM_LANES.
- Data passthrough: no arithmetic is performed on the data; bits pass through unmodified, including NaN payloads and flags.

Test Plan:
1. After reset, lanes 0..4 each present one result in successive cycles: lane0 0x4000 with status 0, lane1 0x3C00, lane2 0x7E00 with status 5'b10000, lane3 0x4200, lane4 0x0000; out_ready_i=1 throughout.
   -> Outputs appear in order 0x4000, 0x3C00, 0x7E00, 0x4200, 0x0000, one cycle after each capture.
   -> out_lane_o goes 0..4 and then wraps to 0.
   -> out_status_o on the third result is 5'b10000.
2. Out-of-order completion: lane2 = 0x4400 in cycle 1, lane1 = 0x3800 in cycle 2, lane0 = 0x3000 in cycle 3.
   -> No output until cycle 4.
   -> Then 0x3000, 0x3800, 0x4400 on consecutive cycles.
   -> pending_o shows 1, 2, 3, 2, 1, 0.
3. Backpressure: out_ready_i=0 with all five slots filled.
   -> pending_o=5, lane_ready_o=5'b00000.
   -> A further lane3_valid sets overflow_o=1 and slot 3 data is unchanged.
   -> Releasing out_ready_i drains all five results in order.
4. Same-cycle drain and refill: ptr=0, slot0 full, out_ready_i=1, lane0_valid with 0x5000.
   -> lane_ready_o[0]=1 and the old value is output.
   -> 0x5000 is held in slot0 and is output after lanes 1..4 have been drained.
5. Flush with slots 1 and 3 full and overflow=1, plus a simultaneous lane2_valid.
   -> Next cycle: pending_o=0, out_valid_o=0, ptr=0, lane2 data discarded.
   -> overflow_o stays 1.
6. RST_i asserted mid-stream with 3 results pending and flush_i=1.
   -> Next cycle all outputs are at their reset values, including overflow_o=0.
